// File: rtl/adder_result_fifo_pkg.sv
// Shared constants for the adder result path.
//   ADDER_DATA_WIDTH : adder result word width, the same value the adder uses
//   FIFO_DEPTH       : result FIFO entries (power of two, >= 2)
//   FIFO_PTR_W       : log2(FIFO_DEPTH), FIFO pointer width
package adder_result_fifo_pkg;

  localparam int unsigned ADDER_DATA_WIDTH = 8;
  localparam int unsigned FIFO_DEPTH       = 4;
  localparam int unsigned FIFO_PTR_W       = 2;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer register.
//   clock   : system clock, rising edge
//   reset_n : synchronous active-low reset, pointer returns to 0
//   inc     : advance the pointer by one this edge
//   ptr     : current pointer value, wraps from 2**PTR_W-1 to 0
module fifo_ptr #(
  parameter int unsigned PTR_W = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (inc) begin
      // Natural binary wrap; full/empty is tracked by the owner's count.
      ptr_q <= ptr_q + PTR_W'(1);
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/adder_result_fifo.sv
// Circular FIFO capturing registered adder results for a stalling consumer.
//   clock, reset_n        : system clock, synchronous active-low reset
//   in_valid/in_data      : adder result strobe and word
//   in_ready              : high while not full
//   out_valid/out_data    : head entry, valid while not empty
//   out_ready             : consumer takes the head this cycle
//   count                 : number of stored entries, 0..DEPTH
//   overflow / clear_ovf  : sticky write-while-full flag and its clear
module adder_result_fifo
  import adder_result_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ADDER_DATA_WIDTH,
  parameter int unsigned DEPTH      = FIFO_DEPTH,
  parameter int unsigned PTR_W      = FIFO_PTR_W
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [PTR_W:0]        count,
  output logic                  overflow,
  input  logic                  clear_ovf
);

  localparam logic [PTR_W:0] CountFull = (PTR_W+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  push, pop;

  // Flags come only from registered count, so no input reaches them combinationally.
  assign in_ready  = (count_q != CountFull);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  fifo_ptr #(
    .PTR_W (PTR_W)
  ) u_wr_ptr (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (push),
    .ptr     (wr_ptr)
  );

  fifo_ptr #(
    .PTR_W (PTR_W)
  ) u_rd_ptr (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (pop),
    .ptr     (rd_ptr)
  );

  // Storage is not reset; pointers and count define what is meaningful.
  always_ff @(posedge clock) begin
    if (reset_n && push) begin
      mem_q[wr_ptr] <= in_data;
    end
  end

  assign out_data = mem_q[rd_ptr];

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // A new overflow event beats a simultaneous clear.
  always_comb begin
    ovf_d = ovf_q;
    if (in_valid && !in_ready) begin
      ovf_d = 1'b1;
    end else if (clear_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count    = count_q;
  assign overflow = ovf_q;

endmodule
